// File: rtl/ram_wr_ctrl_if.sv
// Store-request and RAM byte-port bundle for ram_wr_ctrl.
// master = CPU/store side, slave = the write controller.
interface ram_wr_ctrl_if;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_bw;
    logic        wr_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        busy;
    logic        wr_err;

    modport master (
        output wr_req, wr_addr, wr_data, wr_bw,
        input  wr_ready, mem_we, mem_addr, mem_din, busy, wr_err
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, wr_bw,
        output wr_ready, mem_we, mem_addr, mem_din, busy, wr_err
    );
endinterface

// File: rtl/ram_wr_ctrl.sv
// Buffers CPU byte/word stores and serialises them into byte writes on the data RAM port.
// Optional macro WR_UNALIGNED_EN: word stores keep address bit0 instead of forcing alignment.
module ram_wr_ctrl #(
    parameter logic [15:0] BOUND_L = 16'h0200,
    parameter logic [15:0] BOUND_U = 16'h03FF,
    parameter int unsigned DEPTH   = 2
) (
    input logic          clk,
    input logic          rst_n,
    ram_wr_ctrl_if.slave bus
);
    localparam int unsigned       PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned       CntW    = PtrW + 1;
    localparam logic [CntW-1:0]   CntFull = CntW'(DEPTH);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLo   = 2'd1;
    localparam logic [1:0] StHi   = 2'd2;

    logic [15:0]     fifo_addr_q [DEPTH];
    logic [15:0]     fifo_addr_d [DEPTH];
    logic [15:0]     fifo_data_q [DEPTH];
    logic [15:0]     fifo_data_d [DEPTH];
    logic            fifo_bw_q   [DEPTH];
    logic            fifo_bw_d   [DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic [1:0]  state_q, state_d;
    logic [15:0] cur_addr_q, cur_addr_d;
    logic [15:0] cur_data_q, cur_data_d;
    logic        cur_bw_q, cur_bw_d;

    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_din_q, mem_din_d;
    logic        busy_q, busy_d;
    logic        wr_err_q, wr_err_d;

    logic        push, pop, head_valid, head_bw, in_range;
    logic [15:0] push_addr, head_addr, head_data;
    logic [16:0] head_lo, head_hi;

    assign bus.wr_ready = (count_q != CntFull);
    assign push         = bus.wr_req && bus.wr_ready;

`ifdef WR_UNALIGNED_EN
    assign push_addr = bus.wr_addr;
`else
    assign push_addr = bus.wr_bw ? bus.wr_addr : {bus.wr_addr[15:1], 1'b0};
`endif

    // With an empty FIFO the incoming request is the head, so it launches in the accept cycle.
    always_comb begin
        if (count_q == '0) begin
            head_addr = push_addr;
            head_data = bus.wr_data;
            head_bw   = bus.wr_bw;
        end else begin
            head_addr = fifo_addr_q[rptr_q];
            head_data = fifo_data_q[rptr_q];
            head_bw   = fifo_bw_q[rptr_q];
        end
    end

    assign head_valid = (count_q != '0) || push;
    assign head_lo    = {1'b0, head_addr};
    assign head_hi    = head_lo + {16'd0, ~head_bw};
    assign in_range   = (head_lo >= {1'b0, BOUND_L}) && (head_hi <= {1'b0, BOUND_U});

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        cur_data_d = cur_data_q;
        cur_bw_d   = cur_bw_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        wr_err_d   = 1'b0;
        pop        = 1'b0;

        if (state_q == StLo && !cur_bw_q) begin
            state_d    = StHi;
            mem_we_d   = 1'b1;
            mem_addr_d = cur_addr_q + 16'd1 - BOUND_L;
            mem_din_d  = cur_data_q[15:8];
        end else begin
            state_d = StIdle;
            if (head_valid) begin
                pop = 1'b1;
                if (in_range) begin
                    state_d    = StLo;
                    cur_addr_d = head_addr;
                    cur_data_d = head_data;
                    cur_bw_d   = head_bw;
                    mem_we_d   = 1'b1;
                    mem_addr_d = head_addr - BOUND_L;
                    mem_din_d  = head_data[7:0];
                end else begin
                    wr_err_d = 1'b1;
                end
            end
        end
    end

    // A bypassed request is written and popped in the same cycle, leaving count unchanged.
    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        fifo_bw_d   = fifo_bw_q;
        if (push) begin
            fifo_addr_d[wptr_q] = push_addr;
            fifo_data_d[wptr_q] = bus.wr_data;
            fifo_bw_d[wptr_q]   = bus.wr_bw;
        end
        wptr_d  = wptr_q + PtrW'(push);
        rptr_d  = rptr_q + PtrW'(pop);
        count_d = count_q + CntW'(push) - CntW'(pop);
        busy_d  = (count_d != '0) || (state_d != StIdle) || wr_err_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
                fifo_bw_q[i]   <= 1'b0;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            state_q    <= StIdle;
            cur_addr_q <= '0;
            cur_data_q <= '0;
            cur_bw_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            busy_q     <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            fifo_bw_q   <= fifo_bw_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            cur_data_q  <= cur_data_d;
            cur_bw_q    <= cur_bw_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            busy_q      <= busy_d;
            wr_err_q    <= wr_err_d;
        end
    end

    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.busy     = busy_q;
    assign bus.wr_err   = wr_err_q;
endmodule

// File: doc/ram_wr_ctrl.md
Name: ram_wr_ctrl

Overview:
Write-side controller for the byte-organised data RAM of the MSP430 model, the store-path counterpart to the little-endian double-byte program-memory fetch. It accepts CPU byte and word store requests through a valid/ready handshake and buffers them in a small FIFO. It serialises each request into one or two byte writes on a byte-wide RAM port: low byte at the base address, high byte at address+1. Addresses outside the RAM window are dropped and flagged.

Parameters:
BOUND_L, 16'h0200, lowest valid RAM byte address (inclusive)
BOUND_U, 16'h03FF, highest valid RAM byte address (inclusive)
DEPTH, 2, store-request FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
wr_req  input  1  store request valid
wr_addr  input  16  store byte address (absolute)
wr_data  input  16  store data; byte stores use [7:0]
wr_bw  input  1  1 = byte store, 0 = word store
wr_ready  output  1  FIFO not full; request accepted when wr_req && wr_ready
mem_we  output  1  RAM byte write strobe
mem_addr  output  16  RAM byte offset = address - BOUND_L
mem_din  output  8  RAM byte write data
busy  output  1  FIFO non-empty or byte sequence in progress
wr_err  output  1  one-cycle pulse: out-of-range request dropped

Behaviour:
- Reset (async, rst_n=0): FIFO emptied, state IDLE, mem_we=0, mem_addr=0, mem_din=0, busy=0, wr_err=0, wr_ready=1. Reset mid-sequence aborts it; queued stores are lost and no partial byte is issued after release.
- wr_ready = (count != DEPTH), combinational from registered count. Push and pop in the same cycle are both honoured. Full FIFO: wr_ready=0, and wr_req is ignored with no state change.
- Word alignment: word stores force address bit0=0 before storage.
- Range check at pop time. Byte: BOUND_L <= addr <= BOUND_U. Word: BOUND_L <= addr and addr+1 <= BOUND_U, computed in 17 bits, so 16'hFFFF+1 does not wrap. Failure: entry popped, wr_err=1 for exactly one cycle, no mem_we, state stays IDLE.
- FSM states IDLE, LO, HI; all outputs registered.
  - IDLE: FIFO non-empty and in range -> pop, go to LO.
  - LO: mem_we=1, mem_addr=addr-BOUND_L, mem_din=data[7:0]. Byte store -> IDLE. Word store -> HI.
  - HI: mem_we=1, mem_addr=addr+1-BOUND_L, mem_din=data[15:8] -> IDLE.
  - From LO (byte) or HI, if the FIFO is non-empty, the next entry is popped in the same cycle. Back-to-back stores stream without an idle cycle.
- Latency: request accepted in cycle N into an empty, idle controller -> first mem_we in cycle N+1. Word completes in N+2.
- Throughput: 1 byte/cycle sustained. The FIFO only fills if requests arrive faster than bytes drain.
- busy=1 from the cycle after the first accept until the cycle after the final byte write or error.
- mem_we=0 in all other cycles. mem_addr and mem_din hold their last values when idle.

Optional Feature:
Macro WR_UNALIGNED_EN.
- Defined: word stores keep bit0 unmodified. An odd-address word writes addr (low byte) then addr+1 (high byte), and the range check uses the unaligned addr+1.
- Undefined: bit0 is forced to 0 for word stores as above.
- Byte stores are unaffected either way.

Test Plan:
- Word store addr=16'h0210, data=16'hBEEF, accepted cycle N -> cycle N+1 mem_we=1 mem_addr=16'h0010 mem_din=8'hEF; cycle N+2 mem_addr=16'h0011 mem_din=8'hBE; cycle N+3 mem_we=0, busy=0.
- Byte store addr=16'h0305, data=16'h12A5 -> single write mem_addr=16'h0105 mem_din=8'hA5; high byte never written.
- Out-of-range: byte store to 16'h01FF, then word store to 16'h03FF aligned to 16'h03FE (valid, two writes); word store to 16'h0400 -> one wr_err pulse for 16'h01FF and one for 16'h0400, no mem_we for either.
- Back-to-back: 3 word stores on consecutive cycles with DEPTH=2 -> wr_ready drops once the FIFO is full. Exactly 6 consecutive mem_we cycles in order with no gaps; the held request is accepted when wr_ready returns.
- Reset mid-sequence: rst_n low during the HI cycle of a word store with one entry queued -> outputs immediately at reset values; after release, no mem_we until a new request arrives.
- WR_UNALIGNED_EN defined: word store addr=16'h0211, data=16'h5A3C -> writes mem_addr 16'h0011=8'h3C then 16'h0012=8'h5A. Undefined: writes 16'h0010 and 16'h0011.
